// File: rtl/serial_addsub_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_if
// Request/response bundle for the multi-cycle add/subtract unit.
//   start, op, A, B      : request from the client (master -> slave)
//   ready, done          : handshake status from the unit
//   Result, cOut, V, Z, N: result and condition flags, valid when done pulses
// WIDTH must match the WIDTH of the serial_addsub instance it is bound to.
// ---------------------------------------------------------------------------
interface serial_addsub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             cOut;
    logic             V;
    logic             Z;
    logic             N;

    modport master (
        output start, op, A, B,
        input  ready, done, Result, cOut, V, Z, N
    );

    modport slave (
        input  start, op, A, B,
        output ready, done, Result, cOut, V, Z, N
    );
endinterface

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Multi-cycle add/subtract: CHUNK bits per cycle through one narrow adder
// slice with a registered carry, WIDTH/CHUNK cycles per operation.
//   clock : rising-edge clock
//   clear : synchronous active-low reset
//   bus   : serial_addsub_if.slave
//           start/op/A/B in (sampled only while ready=1),
//           ready (IDLE only), done (one-cycle pulse),
//           Result/cOut/V/Z/N out, updated only on the completing edge.
// Subtraction is A + ~B + 1, so cOut=1 means "no borrow" (A >= B unsigned).
// ---------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic           clock,
    input  logic           clear,
    serial_addsub_if.slave bus
);
    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : gBadParams
        $error("serial_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state;
    stateT            stateNext;

    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;       // already inverted for subtraction
    logic [WIDTH-1:0] work;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [WIDTH-1:0] resultR;
    logic             cOutR;
    logic             vR;
    logic             zR;
    logic             nR;

    // Adder slice for the chunk selected by idx.
    logic [31:0]      base;
    logic [CHUNK-1:0] aChunk;
    logic [CHUNK-1:0] bChunk;
    logic [CHUNK-1:0] sumChunk;
    logic             chunkCarry;
    logic             carryIntoMsb;
    logic [WIDTH-1:0] workNext;
    logic             lastChunk;

    assign base      = 32'(idx) * 32'(CHUNK);
    assign lastChunk = (idx == LAST_IDX);

    // NOTE: every variable written in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        aChunk   = opA[base +: CHUNK];
        bChunk   = opB[base +: CHUNK];
        {chunkCarry, sumChunk} = {1'b0, aChunk} + {1'b0, bChunk} + (CHUNK + 1)'(carry);
        // On the top chunk, the carry into bit WIDTH-1 is recovered from the
        // sum bit and the two operand bits; V is that XOR the final carry.
        carryIntoMsb = aChunk[CHUNK-1] ^ bChunk[CHUNK-1] ^ sumChunk[CHUNK-1];
        workNext = work;
        workNext[base +: CHUNK] = sumChunk;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (bus.start) stateNext = RUN;
            RUN:     if (lastChunk) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            opA     <= '0;
            opB     <= '0;
            work    <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            resultR <= '0;
            cOutR   <= 1'b0;
            vR      <= 1'b0;
            zR      <= 1'b1;
            nR      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        opA   <= bus.A;
                        opB   <= bus.op ? ~bus.B : bus.B;
                        carry <= bus.op;   // the +1 of two's-complement negate
                        idx   <= '0;
                    end
                end
                RUN: begin
                    work  <= workNext;
                    carry <= chunkCarry;
                    idx   <= lastChunk ? '0 : idx + 1'b1;
                    if (lastChunk) begin
                        resultR <= workNext;
                        cOutR   <= chunkCarry;
                        vR      <= carryIntoMsb ^ chunkCarry;
                        zR      <= (workNext == '0);
                        nR      <= workNext[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready  = (state == IDLE);
    assign bus.done   = (state == DONE);
    assign bus.Result = resultR;
    assign bus.cOut   = cOutR;
    assign bus.V      = vR;
    assign bus.Z      = zR;
    assign bus.N      = nR;
endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
// Three instances: WIDTH=32/CHUNK=8, WIDTH=32/CHUNK=32, WIDTH=16/CHUNK=4.
// Expected values come from a plain-arithmetic reference model.
// Flags are compared as the vector {cOut, V, Z, N}.
// ---------------------------------------------------------------------------
module tb_serial_addsub;
    logic clock;
    logic clear;

    int nChecks = 0;
    int nFails  = 0;

    int widthOf [3] = '{32, 32, 16};
    int nchOf   [3] = '{4, 1, 4};

    serial_addsub_if #(.WIDTH(32)) bus0 ();
    serial_addsub_if #(.WIDTH(32)) bus1 ();
    serial_addsub_if #(.WIDTH(16)) bus2 ();

    serial_addsub #(.WIDTH(32), .CHUNK(8))  dut0 (.clock(clock), .clear(clear), .bus(bus0));
    serial_addsub #(.WIDTH(32), .CHUNK(32)) dut1 (.clock(clock), .clear(clear), .bus(bus1));
    serial_addsub #(.WIDTH(16), .CHUNK(4))  dut2 (.clock(clock), .clear(clear), .bus(bus2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: modulo-2^w arithmetic with flags derived from operand signs.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic o, output logic [31:0] r, output logic [3:0] f);
        logic [63:0] mask, am, bm, full;
        logic sa, sb, sr, c, v;
        mask = (64'd1 << w) - 64'd1;
        am   = 64'(a) & mask;
        bm   = 64'(b) & mask;
        full = o ? (am + (~bm & mask) + 64'd1) : (am + bm);
        r    = 32'(full & mask);
        c    = full[w];
        sa   = am[w-1];
        sb   = bm[w-1];
        sr   = full[w-1];
        v    = o ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        f    = {c, v, (r == 32'd0), sr};
    endfunction

    task automatic drive(input int k, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic o);
        case (k)
            0: begin bus0.start = s; bus0.A = a; bus0.B = b; bus0.op = o; end
            1: begin bus1.start = s; bus1.A = a; bus1.B = b; bus1.op = o; end
            default: begin bus2.start = s; bus2.A = a[15:0]; bus2.B = b[15:0]; bus2.op = o; end
        endcase
    endtask

    function automatic logic rdyOf(input int k);
        case (k)
            0:       return bus0.ready;
            1:       return bus1.ready;
            default: return bus2.ready;
        endcase
    endfunction

    function automatic logic doneOf(input int k);
        case (k)
            0:       return bus0.done;
            1:       return bus1.done;
            default: return bus2.done;
        endcase
    endfunction

    function automatic logic [31:0] resOf(input int k);
        case (k)
            0:       return bus0.Result;
            1:       return bus1.Result;
            default: return {16'd0, bus2.Result};
        endcase
    endfunction

    function automatic logic [3:0] flagsOf(input int k);
        case (k)
            0:       return {bus0.cOut, bus0.V, bus0.Z, bus0.N};
            1:       return {bus1.cOut, bus1.V, bus1.Z, bus1.N};
            default: return {bus2.cOut, bus2.V, bus2.Z, bus2.N};
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete operation; poke=1 keeps start asserted through RUN and DONE
    // with different operands, which must all be ignored.
    task automatic doOp(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input bit poke);
        logic [31:0] eRes, prevRes;
        logic [3:0]  eFlags, prevFlags;
        int          edges;
        int          nch;
        nch = nchOf[k];
        model(widthOf[k], a, b, o, eRes, eFlags);
        edges = 0;
        while (!rdyOf(k) && edges < 20) begin
            tick();
            edges++;
        end
        check("ready before start", 64'(rdyOf(k)), 64'd1);
        prevRes   = resOf(k);
        prevFlags = flagsOf(k);
        drive(k, 1'b1, a, b, o);
        tick();
        drive(k, poke, $urandom, $urandom, 1'($urandom));
        edges = 0;
        while (!doneOf(k) && edges < nch + 4) begin
            check("ready low in RUN", 64'(rdyOf(k)), 64'd0);
            check("Result held in RUN", 64'(resOf(k)), 64'(prevRes));
            check("flags held in RUN", 64'(flagsOf(k)), 64'(prevFlags));
            tick();
            edges++;
            if (poke) drive(k, 1'b1, $urandom, $urandom, 1'($urandom));
        end
        check("latency to done", 64'(edges), 64'(nch));
        check("done pulse", 64'(doneOf(k)), 64'd1);
        check("ready low in DONE", 64'(rdyOf(k)), 64'd0);
        check("Result", 64'(resOf(k)), 64'(eRes));
        check("flags cOut,V,Z,N", 64'(flagsOf(k)), 64'(eFlags));
        tick();
        drive(k, 1'b0, $urandom, $urandom, 1'($urandom));
        check("done one cycle only", 64'(doneOf(k)), 64'd0);
        check("ready back after DONE", 64'(rdyOf(k)), 64'd1);
        tick();
        check("start in DONE ignored", 64'(rdyOf(k)), 64'd1);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Directed vectors for the 32/8 instance.
    logic [31:0] dirA  [10] = '{32'd10, 32'd3, 32'd5, 32'h1234, 32'h00FF_FFFF,
                                32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] dirB  [10] = '{32'd3, 32'd10, 32'd5, 32'h0, 32'd1,
                                32'd1, 32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF};
    logic        dirOp [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        logic [31:0] qa [$];
        logic [31:0] qb [$];
        logic        qo [$];
        logic [31:0] eRes, lastRes, a, b;
        logic [3:0]  eFlags;
        logic        o, accepted;
        int          busy;

        clear = 1'b0;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset ready", 64'(rdyOf(k)), 64'd1);
            check("reset done", 64'(doneOf(k)), 64'd0);
            check("reset Result", 64'(resOf(k)), 64'd0);
            check("reset flags", 64'(flagsOf(k)), 64'b0010);
        end
        clear = 1'b1;
        tick();

        // Directed cases, including cross-chunk carries and overflow.
        for (int i = 0; i < 10; i++) doOp(0, dirA[i], dirB[i], dirOp[i], 1'b0);

        // Narrow and single-chunk configurations.
        doOp(1, 32'd10, 32'd3, 1'b1, 1'b0);
        doOp(2, 32'd10, 32'd3, 1'b1, 1'b0);
        doOp(2, 32'h7FFF, 32'd1, 1'b0, 1'b0);
        doOp(2, 32'd3, 32'd10, 1'b1, 1'b1);

        // Randomized operations, some with start held through RUN/DONE.
        for (int i = 0; i < 30; i++)
            doOp(0, pickOperand(), pickOperand(), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 8; i++) begin
            doOp(1, pickOperand(), pickOperand(), 1'($urandom), 1'($urandom));
            doOp(2, pickOperand(), pickOperand(), 1'($urandom), 1'($urandom));
        end

        // start held high with changing operands: only IDLE samples count.
        busy    = 0;
        lastRes = resOf(0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            check("stream ready", 64'(rdyOf(0)), 64'(busy == 0));
            check("stream done", 64'(doneOf(0)), 64'(busy == 1));
            if (doneOf(0) && qa.size() > 0) begin
                model(32, qa.pop_front(), qb.pop_front(), qo.pop_front(), eRes, eFlags);
                check("stream Result", 64'(resOf(0)), 64'(eRes));
                check("stream flags", 64'(flagsOf(0)), 64'(eFlags));
                lastRes = eRes;
            end else begin
                check("stream Result held", 64'(resOf(0)), 64'(lastRes));
            end
            a = $urandom;
            b = $urandom;
            o = 1'($urandom);
            drive(0, (cyc < 30), a, b, o);
            accepted = (cyc < 30) && (busy == 0);
            if (accepted) begin
                qa.push_back(a);
                qb.push_back(b);
                qo.push_back(o);
            end
            tick();
            if (accepted) busy = nchOf[0] + 1;
            else if (busy > 0) busy--;
        end
        check("stream all completed", 64'(qa.size()), 64'd0);

        // Reset during the second RUN cycle aborts without a done pulse.
        doOp(0, 32'h0000_0005, 32'h0000_0009, 1'b0, 1'b0);
        drive(0, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0);
        tick();
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        clear = 1'b0;
        tick();
        clear = 1'b1;
        check("abort ready", 64'(rdyOf(0)), 64'd1);
        check("abort done", 64'(doneOf(0)), 64'd0);
        check("abort Result", 64'(resOf(0)), 64'd0);
        check("abort flags", 64'(flagsOf(0)), 64'b0010);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no done after abort", 64'(doneOf(0)), 64'd0);
        end
        doOp(0, 32'd10, 32'd3, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
